// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor datapath blocks: FSM state
// encoding, buffering constants and default widths.
package coproc_pkg;

    // One-hot so the encoding lines up with the matrix multiply unit's FSM.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    // Entries in the result prefetch FIFO; must be a power of two.
    localparam int RES_FIFO_DEPTH = 4;

    // Cycles from the registered RES_RAM address/enable edge until the
    // word can be captured (data valid after t+1, captured at t+2).
    localparam int RAM_RD_LAT = 2;

    localparam int DEF_WIDTH          = 8;
    localparam int DEF_RES_DEPTH_BITS = 1;
    localparam int DEF_AXIS_WIDTH     = 32;

endpackage

// File: rtl/res_stream_out_if.sv
// Master AXI Stream bundle carrying result words out of the coprocessor.
interface res_stream_out_if
    import coproc_pkg::*;
#(
    parameter int AXIS_width = DEF_AXIS_WIDTH
) ();

    logic                  TVALID;
    logic [AXIS_width-1:0] TDATA;
    logic                  TLAST;
    logic                  TREADY;

    modport master (output TVALID, output TDATA, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);

endinterface

// File: rtl/res_out_fifo.sv
// Small synchronous FIFO holding prefetched result words ({last, data}).
// Push and pop may happen in the same cycle; the head is visible
// combinationally from the storage array so it can drive the stream.
module res_out_fifo
    import coproc_pkg::*;
#(
    parameter int DATA_W = DEF_WIDTH + 1,
    parameter int DEPTH  = RES_FIFO_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push_ok;
    logic w_pop_ok;

    // A pop on empty is dropped; a push into a full FIFO is only taken
    // when a pop frees a slot in the same cycle.
    assign w_pop_ok  = i_pop && (r_count != '0);
    assign w_push_ok = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop_ok);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    // Storage write; contents need no reset because the count gates use.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/res_stream_out.sv
// Result output stage: on Start, reads every RES_RAM word in address order
// and streams each one as an AXI Stream beat, TLAST on the final word,
// then pulses Done. A credit check on (FIFO fill + reads in flight) lets
// reads run ahead so beats can go out back-to-back under constant TREADY.
module res_stream_out
    import coproc_pkg::*;
#(
    parameter int width          = DEF_WIDTH,
    parameter int RES_depth_bits = DEF_RES_DEPTH_BITS,
    parameter int AXIS_width     = DEF_AXIS_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Start,
    output logic                      Busy,
    output logic                      Done,
    output logic                      RES_read_en,
    output logic [RES_depth_bits-1:0] RES_read_address,
    input  logic [width-1:0]          RES_read_data_out,
    res_stream_out_if.master          m_axis
);

    localparam int NUM_WORDS  = 1 << RES_depth_bits;
    localparam int FIFO_CNT_W = $clog2(RES_FIFO_DEPTH + 1);
    localparam logic [RES_depth_bits-1:0] LAST_ADDR = RES_depth_bits'(NUM_WORDS - 1);

    state_t                      r_state;
    logic                        r_busy;
    logic                        r_done;
    // One extra bit so the issue counter can sit one past the last word
    // instead of wrapping back to zero.
    logic [RES_depth_bits:0]     r_rd_addr;
    logic [RES_depth_bits-1:0]   r_read_addr;
    // Stage 0 is the registered read enable itself; the last stage marks
    // the cycle whose RAM data is captured into the FIFO.
    logic [RAM_RD_LAT-1:0]       r_pipe_v;
    logic [RAM_RD_LAT-1:0]       r_pipe_last;

    logic [width:0]              w_head;
    logic [width-1:0]            w_head_data;
    logic                        w_head_last;
    logic [FIFO_CNT_W-1:0]       w_fifo_count;
    logic                        w_fifo_empty;
    logic [FIFO_CNT_W-1:0]       w_inflight;
    logic [FIFO_CNT_W:0]         w_occupancy;
    logic                        w_issue;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_valid;

    // Count reads that have been issued but not yet landed in the FIFO.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RAM_RD_LAT; i++) begin
            w_inflight = w_inflight + FIFO_CNT_W'(r_pipe_v[i]);
        end
    end

    assign w_occupancy = {1'b0, w_fifo_count} + (FIFO_CNT_W + 1)'(w_inflight);
    assign w_issue     = (r_state == ST_RUN) && !r_rd_addr[RES_depth_bits]
                         && (w_occupancy < (FIFO_CNT_W + 1)'(RES_FIFO_DEPTH));
    assign w_push      = r_pipe_v[RAM_RD_LAT-1];
    assign w_valid     = !w_fifo_empty;
    assign w_pop       = w_valid && m_axis.TREADY;

    assign w_head_data = w_head[width-1:0];
    assign w_head_last = w_head[width];

    res_out_fifo #(
        .DATA_W (width + 1),
        .DEPTH  (RES_FIFO_DEPTH),
        .CNT_W  (FIFO_CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({r_pipe_last[RAM_RD_LAT-1], RES_read_data_out}),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    // Control FSM plus the read-issue counter and read-latency pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_addr   <= '0;
            r_read_addr <= '0;
            r_pipe_v    <= '0;
            r_pipe_last <= '0;
        end else begin
            r_pipe_v[0]    <= w_issue;
            r_pipe_last[0] <= w_issue && (r_rd_addr[RES_depth_bits-1:0] == LAST_ADDR);
            for (int i = 1; i < RAM_RD_LAT; i++) begin
                r_pipe_v[i]    <= r_pipe_v[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
            if (w_issue) begin
                r_read_addr <= r_rd_addr[RES_depth_bits-1:0];
                r_rd_addr   <= r_rd_addr + (RES_depth_bits + 1)'(1);
            end
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                        r_rd_addr <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_pop && w_head_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The credit rule must keep FIFO fill plus outstanding reads in bounds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (w_occupancy <= (FIFO_CNT_W + 1)'(RES_FIFO_DEPTH));
        end
    end

    assign Busy             = r_busy;
    assign Done             = r_done;
    assign RES_read_en      = r_pipe_v[0];
    assign RES_read_address = r_read_addr;

    // Outputs are forced to zero while empty so stale storage never shows.
    assign m_axis.TVALID = w_valid;
    assign m_axis.TLAST  = w_valid && w_head_last;

    generate
        if (AXIS_width > width) begin : g_zext
            assign m_axis.TDATA = w_valid ? {{(AXIS_width - width){1'b0}}, w_head_data}
                                          : '0;
        end else begin : g_direct
            assign m_axis.TDATA = w_valid ? w_head_data : '0;
        end
    endgenerate

endmodule

// File: tb/tb_res_stream_out.sv
// Bench for res_stream_out: instance 0 uses 2 words, instance 1 uses 8 words.
// Stimulus pushes the expected beats ({last, data}) for each transfer into a
// per-instance queue; a negedge monitor pops and compares on each handshake.
module tb_res_stream_out;
    import coproc_pkg::*;

    localparam int NW [2] = '{2, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s [2];
    logic        start_s [2];
    logic        busy_s [2];
    logic        done_s [2];
    logic        ren_s [2];
    logic        tvalid_s [2];
    logic        tlast_s [2];
    logic        tready_s [2];
    logic [31:0] tdata_s [2];
    logic [31:0] addr_s [2];
    int          tmode [2];

    logic [0:0]  addr_a;
    logic [2:0]  addr_b;
    logic [7:0]  rdata_a;
    logic [7:0]  rdata_b;
    logic [7:0]  mem [2][8];

    logic [8:0]  q [2][$];
    logic        stall_v [2];
    logic [31:0] stall_d [2];
    logic        stall_l [2];
    int          exp_addr [2];
    int          last_cyc [2];
    int          n_ren [2];
    int          n_done [2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          snap_ren;
    int          snap_done;

    res_stream_out_if #(.AXIS_width(32)) ax_a ();
    res_stream_out_if #(.AXIS_width(32)) ax_b ();

    res_stream_out #(.width(8), .RES_depth_bits(1), .AXIS_width(32)) dut_a (
        .clk(clk), .reset(rst_s[0]), .Start(start_s[0]), .Busy(busy_s[0]), .Done(done_s[0]),
        .RES_read_en(ren_s[0]), .RES_read_address(addr_a), .RES_read_data_out(rdata_a),
        .m_axis(ax_a));

    res_stream_out #(.width(8), .RES_depth_bits(3), .AXIS_width(32)) dut_b (
        .clk(clk), .reset(rst_s[1]), .Start(start_s[1]), .Busy(busy_s[1]), .Done(done_s[1]),
        .RES_read_en(ren_s[1]), .RES_read_address(addr_b), .RES_read_data_out(rdata_b),
        .m_axis(ax_b));

    assign addr_s[0]   = 32'(addr_a);
    assign addr_s[1]   = 32'(addr_b);
    assign tvalid_s[0] = ax_a.TVALID;
    assign tvalid_s[1] = ax_b.TVALID;
    assign tlast_s[0]  = ax_a.TLAST;
    assign tlast_s[1]  = ax_b.TLAST;
    assign tdata_s[0]  = ax_a.TDATA;
    assign tdata_s[1]  = ax_b.TDATA;
    assign ax_a.TREADY = tready_s[0];
    assign ax_b.TREADY = tready_s[1];

    // RES_RAM models: address/enable sampled on the edge after issue.
    always @(posedge clk) if (ren_s[0]) rdata_a <= mem[0][addr_a];
    always @(posedge clk) if (ren_s[1]) rdata_b <= mem[1][addr_b];

    // TREADY drivers: 0 low, 1 high, 2 random, 3 alternating.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            case (tmode[k])
                0:       tready_s[k] = 1'b0;
                1:       tready_s[k] = 1'b1;
                2:       tready_s[k] = 1'($urandom_range(0, 1));
                default: tready_s[k] = (tready_s[k] === 1'b1) ? 1'b0 : 1'b1;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        logic [8:0] e;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (ren_s[k]) begin
                n_ren[k]++;
                chk("read_addr_order", addr_s[k], 32'(exp_addr[k]));
                exp_addr[k]++;
            end
            if (!busy_s[k]) exp_addr[k] = 0;
            if (done_s[k]) begin
                n_done[k]++;
                chk("done_after_last", 32'(cyc - last_cyc[k]), 32'd1);
            end
            if (rst_s[k]) begin
                stall_v[k] = 1'b0;
            end else begin
                if (stall_v[k]) begin
                    chk("hold_valid", 32'(tvalid_s[k]), 32'd1);
                    chk("hold_data", tdata_s[k], stall_d[k]);
                    chk("hold_last", 32'(tlast_s[k]), 32'(stall_l[k]));
                end
                if (tvalid_s[k] && tready_s[k]) begin
                    $display("beat inst=%0d data=%08h last=%0b", k, tdata_s[k], tlast_s[k]);
                    if (q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_unexpected: actual %08h required none", tdata_s[k]);
                    end else begin
                        e = q[k].pop_front();
                        chk("beat_data", tdata_s[k], {24'h0, e[7:0]});
                        chk("beat_last", 32'(tlast_s[k]), 32'(e[8]));
                        if (e[8]) last_cyc[k] = cyc;
                    end
                end
                stall_v[k] = tvalid_s[k] && !tready_s[k];
                stall_d[k] = tdata_s[k];
                stall_l[k] = tlast_s[k];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one beat per word in address order, last on the final.
    task automatic load_expect(input int k);
        for (int i = 0; i < NW[k]; i++)
            q[k].push_back({(i == NW[k] - 1) ? 1'b1 : 1'b0, mem[k][i]});
    endtask

    task automatic wait_done(input int k, input string name);
        int n = 0;
        while (done_s[k] !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk({name, "_done"}, 32'(done_s[k]), 32'd1);
        step();
        chk({name, "_done_pulse"}, 32'(done_s[k]), 32'd0);
        chk({name, "_busy_drop"}, 32'(busy_s[k]), 32'd0);
    endtask

    task automatic transfer(input int k, input int mode, input bit rnd, input bit repulse,
                            input string name);
        if (rnd) for (int i = 0; i < NW[k]; i++) mem[k][i] = 8'($urandom);
        tmode[k]  = mode;
        snap_ren  = n_ren[k];
        snap_done = n_done[k];
        load_expect(k);
        start_s[k] = 1'b1;
        step();
        start_s[k] = 1'b0;
        if (repulse) begin
            step();
            start_s[k] = 1'b1;
            step();
            start_s[k] = 1'b0;
        end
        wait_done(k, name);
        chk({name, "_reads"}, 32'(n_ren[k] - snap_ren), 32'(NW[k]));
        chk({name, "_dones"}, 32'(n_done[k] - snap_done), 32'd1);
        chk({name, "_drained"}, 32'(q[k].size()), 32'd0);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            rst_s[k] = 1'b1; start_s[k] = 1'b0; tmode[k] = 0;
            stall_v[k] = 1'b0; exp_addr[k] = 0; last_cyc[k] = 0; n_ren[k] = 0; n_done[k] = 0;
            for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;
        end
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("rst_tvalid", 32'(tvalid_s[k]), 32'd0);
            chk("rst_tdata", tdata_s[k], 32'd0);
            chk("rst_tlast", 32'(tlast_s[k]), 32'd0);
            chk("rst_busy", 32'(busy_s[k]), 32'd0);
            chk("rst_done", 32'(done_s[k]), 32'd0);
            chk("rst_ren", 32'(ren_s[k]), 32'd0);
            chk("rst_addr", addr_s[k], 32'd0);
            rst_s[k] = 1'b0;
        end
        step();

        // Test 1: two words, TREADY high, exact latency.
        mem[0][0] = 8'h12; mem[0][1] = 8'h34;
        tmode[0] = 1;
        step(); step();
        snap_ren = n_ren[0]; snap_done = n_done[0];
        load_expect(0);
        start_s[0] = 1'b1;
        step();                                   // edge 0
        start_s[0] = 1'b0;
        chk("t1_busy_e0", 32'(busy_s[0]), 32'd1);
        chk("t1_tvalid_e0", 32'(tvalid_s[0]), 32'd0);
        step();                                   // edge 1
        chk("t1_ren_e1", 32'(ren_s[0]), 32'd1);
        chk("t1_addr_e1", addr_s[0], 32'd0);
        step();                                   // edge 2
        chk("t1_tvalid_e2", 32'(tvalid_s[0]), 32'd0);
        step();                                   // edge 3
        chk("t1_tvalid_e3", 32'(tvalid_s[0]), 32'd1);
        chk("t1_tdata_e3", tdata_s[0], 32'h00000012);
        step();                                   // edge 4
        chk("t1_tdata_e4", tdata_s[0], 32'h00000034);
        chk("t1_tlast_e4", 32'(tlast_s[0]), 32'd1);
        step();                                   // edge 5
        chk("t1_done_e5", 32'(done_s[0]), 32'd1);
        chk("t1_busy_e5", 32'(busy_s[0]), 32'd1);
        chk("t1_tvalid_e5", 32'(tvalid_s[0]), 32'd0);
        step();                                   // edge 6
        chk("t1_done_e6", 32'(done_s[0]), 32'd0);
        chk("t1_busy_e6", 32'(busy_s[0]), 32'd0);
        chk("t1_reads", 32'(n_ren[0] - snap_ren), 32'd2);
        chk("t1_dones", 32'(n_done[0] - snap_done), 32'd1);

        // Test 2: backpressure for 6 cycles after TVALID rises.
        tmode[0] = 0;
        step(); step();
        snap_done = n_done[0];
        load_expect(0);
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        n = 0;
        while (tvalid_s[0] !== 1'b1 && n < 20) begin step(); n++; end
        chk("t2_tvalid_rise", 32'(tvalid_s[0]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("t2_hold_tdata", tdata_s[0], 32'h00000012);
            chk("t2_hold_tlast", 32'(tlast_s[0]), 32'd0);
            step();
        end
        tmode[0] = 1;
        wait_done(0, "t2");
        chk("t2_dones", 32'(n_done[0] - snap_done), 32'd1);
        chk("t2_drained", 32'(q[0].size()), 32'd0);

        // Test 4: Start re-pulsed while busy is ignored.
        transfer(0, 2, 1'b0, 1'b1, "t4");

        // Test 5: reset one cycle after the first handshake.
        mem[0][0] = 8'h12; mem[0][1] = 8'h34;
        tmode[0] = 1;
        step(); step();
        load_expect(0);
        start_s[0] = 1'b1;
        step();                                   // edge 0
        start_s[0] = 1'b0;
        repeat (4) step();                        // edge 4: first handshake
        rst_s[0] = 1'b1;
        step();                                   // edge 5: reset sampled
        rst_s[0] = 1'b0;
        q[0].delete();
        chk("t5_tvalid", 32'(tvalid_s[0]), 32'd0);
        chk("t5_ren", 32'(ren_s[0]), 32'd0);
        chk("t5_done", 32'(done_s[0]), 32'd0);
        chk("t5_busy", 32'(busy_s[0]), 32'd0);
        snap_ren = n_ren[0]; snap_done = n_done[0];
        repeat (5) step();
        chk("t5_no_reads", 32'(n_ren[0] - snap_ren), 32'd0);
        chk("t5_no_done", 32'(n_done[0] - snap_done), 32'd0);
        transfer(0, 1, 1'b0, 1'b0, "t5_restart");

        // Test 6: Start and reset on the same edge.
        snap_ren = n_ren[0];
        start_s[0] = 1'b1; rst_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0; rst_s[0] = 1'b0;
        chk("t6_busy", 32'(busy_s[0]), 32'd0);
        repeat (4) step();
        chk("t6_busy_later", 32'(busy_s[0]), 32'd0);
        chk("t6_tvalid", 32'(tvalid_s[0]), 32'd0);
        chk("t6_no_reads", 32'(n_ren[0] - snap_ren), 32'd0);

        // Randomized transfers on the 2-word instance.
        for (int r = 0; r < 6; r++) transfer(0, 2, 1'b1, 1'b0, "rand_a");

        // Test 3: eight words, alternating TREADY.
        for (int i = 0; i < 8; i++) mem[1][i] = 8'h10 + 8'(i);
        transfer(1, 3, 1'b0, 1'b0, "t3");
        transfer(1, 1, 1'b0, 1'b0, "t3_full_rate");

        // Randomized transfers on the 8-word instance.
        for (int r = 0; r < 5; r++) transfer(1, 2, 1'b1, r[0], "rand_b");

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/res_stream_out.md
Name: res_stream_out

Overview:
- Output stage directly downstream of the matrix multiply unit inside the AXI Stream coprocessor.
- On Start (driven by the multiplier's Done), reads every RES_RAM location in address order through the RAM's synchronous read port and emits each word as one beat on the master AXI Stream.
- Marks the final beat with TLAST, then pulses Done to the top-level controller.
- Keeps a small prefetch FIFO so it can sustain one beat per cycle under continuous TREADY while honouring backpressure.

Parameters:
- width, 8, bits per RES_RAM location.
- RES_depth_bits, 1, RES_RAM address bits; number of words NUM_WORDS = 2^RES_depth_bits.
- AXIS_width, 32, M_AXIS_TDATA width; must be >= width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse from the matrix multiply unit's Done; sampled only in IDLE.
- Busy  out  1  high from the cycle after Start is accepted until the cycle Done is high, inclusive.
- Done  out  1  one-cycle pulse after the last beat handshakes.
- RES_read_en  out  1  RES_RAM read enable.
- RES_read_address  out  RES_depth_bits  RES_RAM read address.
- RES_read_data_out  in  width  RES_RAM read data; valid 2 cycles after the address/enable edge.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TDATA  out  AXIS_width  zero-extended RES word.
- M_AXIS_TLAST  out  1  high on beat NUM_WORDS-1 only.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Reset: all outputs 0, FIFO emptied, counters 0, state IDLE. Reset wins over any simultaneous Start/TREADY. Reset mid-transfer abandons the transfer: TVALID low the next cycle, no Done, no further reads.
- States:
  - IDLE: Start=1 -> RUN. Start is ignored in every other state.
  - RUN: issue reads and stream beats. When the last beat handshakes -> DONE.
  - DONE: Done=1 for exactly one cycle, then -> IDLE.
- Read issue (RUN): rd_addr counts 0..NUM_WORDS-1 and never wraps. A read is issued in a cycle iff rd_addr has not passed the last word and (fifo_count + inflight) < 4.
  - Issuing means RES_read_en=1 and RES_read_address=rd_addr, both registered.
  - RES_read_en=0 in every cycle with no issue.
- Read latency: data for a read registered at edge t is valid after edge t+1 and is pushed into the FIFO at edge t+2. inflight tracks 0..2 outstanding reads.
- FIFO: 4 entries, each {data, last}. last is set on the entry read from address NUM_WORDS-1. Push and pop may occur in the same cycle. The credit rule guarantees the FIFO never overflows.
- Stream:
  - TVALID = FIFO non-empty. TDATA = {zeros, head data}. TLAST = head last.
  - Handshake (TVALID & TREADY) pops the head.
  - TDATA and TLAST are stable while TVALID=1 and TREADY=0.
  - TVALID never deasserts without a handshake, except on reset.
- Latency: Start sampled at edge 0 gives first read at edge 1 and TVALID=1 after edge 3. With TREADY held high, beats are back-to-back, 1 per cycle.
- Done: asserted after the edge on which the TLAST beat handshakes, for one cycle. Busy drops the cycle after.
- NUM_WORDS=1: the single beat carries TLAST.

Decomposition:
- Shared package (coproc_pkg):
  - state encoding constants (IDLE, RUN, DONE; one-hot to match the multiply unit);
  - FIFO depth constant RES_FIFO_DEPTH=4;
  - RAM read latency constant RAM_RD_LAT=2;
  - default width / AXIS_width.
- One sub-module: res_out_fifo (synchronous, parameterised width+1 bits × 4 entries, push/pop/count, same-cycle push+pop).

Test Plan:
1. Default params, RES={0x12,0x34}, TREADY=1, Start at edge 0 -> TVALID first high after edge 3; beats 0x00000012 then 0x00000034 on consecutive cycles; TLAST only on the second; Done single-cycle pulse immediately after; exactly 2 RES_read_en cycles.
2. Same data, TREADY=0 for 6 cycles after TVALID rises -> TDATA holds 0x00000012 and TLAST=0 throughout; FIFO holds both words; output order and TLAST unchanged after TREADY=1.
3. RES_depth_bits=3, RES[i]=0x10+i, TREADY pattern 1,0,1,0,... -> 8 beats 0x10..0x17 in order; TLAST only on 0x17; RES_read_address never exceeds 7; (fifo_count+inflight)≤4 at every cycle (assertion).
4. Start re-pulsed while Busy=1 -> ignored; exactly NUM_WORDS beats and one Done.
5. reset asserted one cycle after the first handshake -> TVALID=0, RES_read_en=0, Done=0 next cycle. A new Start then streams from 0x00000012 again.
6. Start and reset high on the same edge -> remains IDLE, Busy=0, no reads issued.
